// File: rtl/pooling_stream.sv
// Streaming pooling engine. CH channels are pooled in parallel over windows of
// WIN serial beats. Modes are max, min, rounded average and saturating sum on
// signed IL.FL fixed-point data. The result is held until the consumer takes it.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for the first beat of a window; accumulators get loaded
// ACC   | folding beats 2..WIN into the accumulators; stalls on !in_valid
// DONE  | result registered on out_data; waiting for output_taken
module pooling_stream #(
    parameter int IL  = 4,
    parameter int FL  = 16,
    parameter int CH  = 4,
    parameter int WIN = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               mode,
    input  logic                     in_valid,
    input  logic [CH*(IL+FL)-1:0]    in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [CH*(IL+FL)-1:0]    out_data,
    input  logic                     output_taken,
    output logic [1:0]               state,
    output logic [$clog2(WIN)-1:0]   count
);

    localparam int W  = IL + FL;
    localparam int LG = $clog2(WIN);
    localparam int CW = $clog2(WIN);
    // Headroom of LG bits lets a full window of sums accumulate without wrap.
    localparam int AW = W + LG;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_ACC  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic [1:0] MODE_MAX = 2'b00;
    localparam logic [1:0] MODE_MIN = 2'b01;
    localparam logic [1:0] MODE_AVG = 2'b10;

    localparam logic signed [AW-1:0] SAT_MAX = {{(LG+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(LG+1){1'b1}}, {(W-1){1'b0}}};
    localparam logic signed [AW-1:0] HALF    = AW'(WIN / 2);

    logic [1:0]             mode_r;
    logic signed [AW-1:0]   acc      [CH];
    logic signed [AW-1:0]   xe       [CH];
    logic signed [AW-1:0]   acc_nxt  [CH];
    logic signed [AW-1:0]   pre      [CH];
    logic [CH*W-1:0]        res_pk;
    logic                   last_beat;

    // Handshake outputs depend on state only, never on in_valid/output_taken.
    always_comb begin
        in_ready  = (state == ST_IDLE) || (state == ST_ACC);
        out_valid = (state == ST_DONE);
    end

    // The window completes on the beat accepted while count == WIN-1 in ACC.
    always_comb begin
        last_beat = (state == ST_ACC) && (count == CW'(WIN - 1));
    end

    // Next accumulator value per channel: load on first beat, fold afterwards.
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            xe[c] = {{LG{in_data[c*W + W - 1]}}, in_data[c*W +: W]};
            if (state == ST_IDLE) begin
                acc_nxt[c] = xe[c];
            end else begin
                case (mode_r)
                    MODE_MAX: acc_nxt[c] = (xe[c] > acc[c]) ? xe[c] : acc[c];
                    MODE_MIN: acc_nxt[c] = (xe[c] < acc[c]) ? xe[c] : acc[c];
                    default:  acc_nxt[c] = acc[c] + xe[c];
                endcase
            end
        end
    end

    // Result per channel. Average rounds half toward +inf via the +WIN/2 bias
    // before the arithmetic shift. The clamp is what makes sum saturate; for
    // max/min/avg the value is already inside W bits, so it never triggers.
    always_comb begin
        res_pk = '0;
        for (int c = 0; c < CH; c++) begin
            if (mode_r == MODE_AVG) begin
                pre[c] = (acc_nxt[c] + HALF) >>> LG;
            end else begin
                pre[c] = acc_nxt[c];
            end
            if (pre[c] > SAT_MAX) begin
                res_pk[c*W +: W] = SAT_MAX[W-1:0];
            end else if (pre[c] < SAT_MIN) begin
                res_pk[c*W +: W] = SAT_MIN[W-1:0];
            end else begin
                res_pk[c*W +: W] = pre[c][W-1:0];
            end
        end
    end

    // Window sequencing: accumulate, register result, hold until taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            count    <= '0;
            mode_r   <= '0;
            out_data <= '0;
            for (int c = 0; c < CH; c++) begin
                acc[c] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        mode_r <= mode;
                        for (int c = 0; c < CH; c++) begin
                            acc[c] <= acc_nxt[c];
                        end
                        count <= CW'(1);
                        state <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (in_valid) begin
                        for (int c = 0; c < CH; c++) begin
                            acc[c] <= acc_nxt[c];
                        end
                        if (last_beat) begin
                            out_data <= res_pk;
                            count    <= '0;
                            state    <= ST_DONE;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (output_taken) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pooling_stream.sv
// Directed bench for pooling_stream (CH=2, WIN=4, 20-bit data). Stimulus pushes
// the hand-computed window result into a queue; a negedge monitor pops and
// compares whenever out_valid rises, and checks out_data stays put while held.
module tb_pooling_stream;

    localparam int IL  = 4;
    localparam int FL  = 16;
    localparam int CH  = 2;
    localparam int WIN = 4;
    localparam int W   = IL + FL;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [1:0]         mode = 2'b00;
    logic               in_valid = 1'b0;
    logic [CH*W-1:0]    in_data = '0;
    logic               in_ready;
    logic               out_valid;
    logic [CH*W-1:0]    out_data;
    logic               output_taken = 1'b0;
    logic [1:0]         state;
    logic [1:0]         count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [CH*W-1:0] exp_q [$];
    int da [4];
    int db [4];

    always #5 clk = ~clk;

    pooling_stream #(.IL(IL), .FL(FL), .CH(CH), .WIN(WIN)) dut (
        .clk          (clk),
        .reset        (reset),
        .mode         (mode),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .output_taken (output_taken),
        .state        (state),
        .count        (count)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [CH*W-1:0] pk(input int a, input int b);
        pk = {b[W-1:0], a[W-1:0]};
    endfunction

    function automatic int chv(input logic [CH*W-1:0] v, input int c);
        logic signed [W-1:0] t;
        t = v[c*W +: W];
        return int'(t);
    endfunction

    // Scoreboard monitor
    logic            ov_prev = 1'b0;
    logic [CH*W-1:0] held = '0;
    logic [CH*W-1:0] e;
    always @(negedge clk) begin
        if (out_valid && !ov_prev) begin
            held = out_data;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_unexpected: got ch0=%0d ch1=%0d, required no output",
                         chv(out_data, 0), chv(out_data, 1));
            end else begin
                e = exp_q.pop_front();
                check("sb_ch0", chv(out_data, 0), chv(e, 0));
                check("sb_ch1", chv(out_data, 1), chv(e, 1));
            end
        end else if (out_valid && ov_prev) begin
            check("hold_stable", out_data, held);
        end
        ov_prev = out_valid;
    end

    task automatic beat(input logic [1:0] m, input int a, input int b);
        mode     = m;
        in_valid = 1'b1;
        in_data  = pk(a, b);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic take();
        output_taken = 1'b1;
        @(posedge clk);
        #1;
        output_taken = 1'b0;
        check("take_state", state, 0);
        check("take_valid", out_valid, 0);
        check("take_count", count, 0);
    endtask

    task automatic check_done();
        check("done_state", state, 2);
        check("done_valid", out_valid, 1);
        check("done_ready", in_ready, 0);
        check("done_count", count, 0);
    endtask

    task automatic full_window(input logic [1:0] m, input int e0, input int e1);
        exp_q.push_back(pk(e0, e1));
        check("idle_ready", in_ready, 1);
        check("idle_count", count, 0);
        for (int i = 0; i < WIN; i++) begin
            beat(m, da[i], db[i]);
            if (i < WIN - 1) begin
                check("acc_state", state, 1);
                check("acc_count", count, i + 1);
            end
        end
        check_done();
        repeat (2) @(posedge clk);
        #1;
        check("done_wait_state", state, 2);
        check("done_wait_ready", in_ready, 0);
        take();
    endtask

    task automatic set_base();
        da = '{520, 360, 1378, 280};
        db = '{-5, -1, -7, -3};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_state", state, 0);
        check("rst_count", count, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        reset = 1'b1;
        #1;
        check("rst_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Max, min, average
        set_base();
        full_window(2'b00, 1378, -1);
        full_window(2'b01, 280, -7);
        full_window(2'b10, 635, -4);

        // Saturating sum
        da = '{300000, 300000, 300000, 300000};
        db = '{-300000, -300000, -300000, -300000};
        full_window(2'b11, 524287, -524288);

        // Stall after beat 2 with a mode change that must be ignored
        set_base();
        exp_q.push_back(pk(1378, -1));
        beat(2'b00, da[0], db[0]);
        beat(2'b00, da[1], db[1]);
        mode = 2'b01;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("stall_count", count, 2);
            check("stall_state", state, 1);
        end
        beat(2'b01, da[2], db[2]);
        beat(2'b01, da[3], db[3]);
        check_done();
        take();

        // Hold in DONE while in_valid is pushing new data
        exp_q.push_back(pk(280, -7));
        for (int i = 0; i < WIN; i++) beat(2'b01, da[i], db[i]);
        check_done();
        in_valid = 1'b1;
        in_data  = pk(9999, -9999);
        mode     = 2'b11;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("hold_state", state, 2);
            check("hold_count", count, 0);
        end
        in_valid = 1'b0;
        take();
        full_window(2'b10, 635, -4);

        // Reset mid-window after beat 3
        da = '{100, 200, 300, 401};
        db = '{-100, -200, -300, -401};
        for (int i = 0; i < 3; i++) beat(2'b00, 7000 + i, 7000 + i);
        check("pre_rst_count", count, 3);
        reset = 1'b0;
        #1;
        check("mid_rst_state", state, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("post_rst_ready", in_ready, 1);
        full_window(2'b10, 250, -250);

        repeat (3) @(posedge clk);
        check("sb_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
